wb_regfile: RTL and testbench

//   Write-back stage and register file that consume the MEM/WB pipeline register outputs.

---
 rtl/wb_regfile_if.sv | 30 +++
 rtl/wb_regfile.sv | 68 ++++++
 tb/tb_wb_regfile.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Write-back / register-file bus: MEM/WB write-back inputs, decode-stage read ports
// and the debug status outputs, grouped so the pipeline stages connect through one port.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32,
  parameter int IDX_W  = 5
);
  logic              MemtoReg;
  logic              RegWrite;
  logic [IDX_W-1:0]  wn;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] Muxout;
  logic [IDX_W-1:0]  rn1;
  logic [IDX_W-1:0]  rn2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic [CNT_W-1:0]  wb_count;

  modport master (
    output MemtoReg, RegWrite, wn, rd_data, Muxout, rn1, rn2,
    input  rdata1, rdata2, wb_data, wb_valid, wb_count
  );

  modport slave (
    input  MemtoReg, RegWrite, wn, rd_data, Muxout, rn1, rn2,
    output rdata1, rdata2, wb_data, wb_valid, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage plus GPR file: selects load/ALU data, commits it to a register file
// with r0 hard-wired to zero, and serves two bypassed combinational read ports.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_regfile_if.slave   bus
);

  logic [DATA_W-1:0] r_gpr [NREG];
  logic              r_wb_valid;
  logic [CNT_W-1:0]  r_wb_count;

  logic [DATA_W-1:0] w_wb_data;
  logic              w_commit;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;

  assign w_wb_data = bus.MemtoReg ? bus.rd_data : bus.Muxout;
  assign w_commit  = bus.RegWrite && (bus.wn != '0);

  // Bypass gives write-before-read: a reader of the register being written sees the new
  // value this cycle. Gating with w_commit also keeps wn/data don't-care when RegWrite=0.
  always_comb begin
    // NOTE: default assigned first so every path drives the output -- no latch inferred.
    w_rdata1 = r_gpr[bus.rn1];
    if (bus.rn1 == '0)
      w_rdata1 = '0;
    else if (w_commit && (bus.wn == bus.rn1))
      w_rdata1 = w_wb_data;
  end

  always_comb begin
    w_rdata2 = r_gpr[bus.rn2];
    if (bus.rn2 == '0)
      w_rdata2 = '0;
    else if (w_commit && (bus.wn == bus.rn2))
      w_rdata2 = w_wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the GPR array is built from flops and must read zero after reset, so it is
      // cleared here; a RAM-based file could not be reset this way.
      for (int i = 0; i < NREG; i++)
        r_gpr[i] <= '0;
      r_wb_valid <= 1'b0;
      r_wb_count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      if (w_commit) begin
        r_gpr[bus.wn] <= w_wb_data;
        r_wb_count    <= r_wb_count + CNT_W'(1);
      end
      r_wb_valid <= w_commit;
    end
  end

  assign bus.wb_data  = w_wb_data;
  assign bus.rdata1   = w_rdata1;
  assign bus.rdata2   = w_rdata2;
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_count = r_wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized regression
// against an array model of the register file (counter narrowed to 4 bits to exercise wrap).
module tb_wb_regfile;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst_n;

  wb_regfile_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .IDX_W(5)) bus ();

  wb_regfile #(.DATA_W(DATA_W), .NREG(32), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural register contents and status, plus current inputs.
  logic [31:0] m_gpr [32];
  logic        m_valid;
  int          m_count;
  logic        m_we, m_mtr;
  logic [4:0]  m_wn, m_rn1, m_rn2;
  logic [31:0] m_rdd, m_mux;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_wbdata();
    return m_mtr ? m_rdd : m_mux;
  endfunction

  // The value a decode-stage read should see: zero for r0, otherwise the register's
  // content as it will stand once this cycle's write-back lands.
  function automatic logic [31:0] m_read(input logic [4:0] rn);
    if (rn == 5'd0) return 32'd0;
    if (m_we && m_wn == rn) return m_wbdata();
    return m_gpr[rn];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_valid = 1'b0;
    m_count = 0;
  endtask

  task automatic apply(input logic we, input logic mtr, input logic [4:0] wn,
                       input logic [31:0] rdd, input logic [31:0] mux,
                       input logic [4:0] rn1, input logic [4:0] rn2);
    m_we = we; m_mtr = mtr; m_wn = wn; m_rdd = rdd; m_mux = mux; m_rn1 = rn1; m_rn2 = rn2;
    bus.RegWrite = we;
    bus.MemtoReg = mtr;
    bus.wn       = wn;
    bus.rd_data  = rdd;
    bus.Muxout   = mux;
    bus.rn1      = rn1;
    bus.rn2      = rn2;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".wb_data"},  bus.wb_data, m_wbdata());
    check({tag, ".rdata1"},   bus.rdata1,  m_read(m_rn1));
    check({tag, ".rdata2"},   bus.rdata2,  m_read(m_rn2));
    check({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'(m_valid));
    check({tag, ".wb_count"}, 32'(bus.wb_count), 32'(m_count));
  endtask

  // Advance one rising edge; the model commits only if reset is released at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (m_we && m_wn != 5'd0) begin
        m_gpr[m_wn] = m_wbdata();
        m_count     = (m_count + 1) % (1 << CNT_W);
      end
      m_valid = m_we && (m_wn != 5'd0);
    end
    #1;
  endtask

  // Apply inputs, check all outputs mid-cycle, then clock.
  task automatic step(input string tag, input logic we, input logic mtr, input logic [4:0] wn,
                      input logic [31:0] rdd, input logic [31:0] mux,
                      input logic [4:0] rn1, input logic [4:0] rn2);
    apply(we, mtr, wn, rdd, mux, rn1, rn2);
    @(negedge clk);
    compare_all(tag);
    tick();
  endtask

  int saved_count;
  logic        r_we, r_mtr;
  logic [4:0]  r_wn, r_rn1, r_rn2;
  logic [31:0] r_rdd, r_mux;

  initial begin
    rst_n = 1'b0;
    model_reset();
    apply(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    #23;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    apply(1'b0, 1'b0, 5'd9, 32'h0, 32'h0, 5'd9, 5'd31);
    @(negedge clk);
    compare_all("reset_state");
    tick();

    // ALU write to r5, then read back
    step("alu_wr", 1'b1, 1'b0, 5'd5, 32'hCAFE_0000, 32'h1234_5678, 5'd5, 5'd0);
    apply(1'b0, 1'b0, 5'd5, 32'h0, 32'h0, 5'd5, 5'd1);
    @(negedge clk);
    check("alu_rd.rdata1", bus.rdata1, 32'h1234_5678);
    check("alu_rd.wb_valid", 32'(bus.wb_valid), 32'd1);
    check("alu_rd.wb_count", 32'(bus.wb_count), 32'd1);
    tick();

    // Load write with same-cycle bypass on both ports
    apply(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h5555_5555, 5'd7, 5'd7);
    @(negedge clk);
    check("ld_bypass.rdata1", bus.rdata1, 32'hDEAD_BEEF);
    check("ld_bypass.rdata2", bus.rdata2, 32'hDEAD_BEEF);
    check("ld_bypass.wb_data", bus.wb_data, 32'hDEAD_BEEF);
    tick();
    apply(1'b0, 1'b0, 5'd7, 32'h0, 32'h0, 5'd7, 5'd5);
    @(negedge clk);
    check("ld_held.rdata1", bus.rdata1, 32'hDEAD_BEEF);
    check("ld_held.rdata2", bus.rdata2, 32'h1234_5678);
    tick();

    // r0 protection
    saved_count = m_count;
    apply(1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    @(negedge clk);
    check("r0_wr.rdata1", bus.rdata1, 32'd0);
    tick();
    apply(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    check("r0_after.rdata1", bus.rdata1, 32'd0);
    check("r0_after.wb_valid", 32'(bus.wb_valid), 32'd0);
    check("r0_after.wb_count", 32'(bus.wb_count), 32'(saved_count));
    tick();

    // Disabled write leaves r3 untouched
    step("r3_init", 1'b1, 1'b0, 5'd3, 32'h0, 32'h0000_0011, 5'd0, 5'd0);
    saved_count = m_count;
    apply(1'b0, 1'b0, 5'd3, 32'hBBBB_BBBB, 32'hAAAA_AAAA, 5'd3, 5'd3);
    @(negedge clk);
    check("dis_before.rdata1", bus.rdata1, 32'h0000_0011);
    tick();
    @(negedge clk);
    check("dis_after.rdata2", bus.rdata2, 32'h0000_0011);
    check("dis_after.wb_count", 32'(bus.wb_count), 32'(saved_count));
    tick();

    // Asynchronous reset mid-operation
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    apply(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd7);
    #1;
    check("async_rst.rdata1", bus.rdata1, 32'd0);
    check("async_rst.rdata2", bus.rdata2, 32'd0);
    check("async_rst.wb_count", 32'(bus.wb_count), 32'd0);
    check("async_rst.wb_valid", 32'(bus.wb_valid), 32'd0);
    // Write presented at an edge while reset is still low is not committed
    apply(1'b1, 1'b0, 5'd4, 32'h0, 32'h7777_7777, 5'd4, 5'd0);
    tick();
    @(negedge clk); #1;
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd0);
    #1;
    check("rst_edge.rdata1", bus.rdata1, 32'd0);
    check("rst_edge.wb_count", 32'(bus.wb_count), 32'd0);
    tick();

    // Counter wrap: 17 commits across r1..r31 from zero wraps a 4-bit count to 1
    for (int k = 0; k < 17; k++)
      step("wrap", 1'b1, k[0], 5'((k % 31) + 1), $urandom, $urandom, 5'((k % 31) + 1), 5'd0);
    apply(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd17);
    @(negedge clk);
    check("wrap.wb_count", 32'(bus.wb_count), 32'd1);
    compare_all("wrap_state");
    tick();

    // Randomized regression with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      r_we  = ($urandom_range(0, 9) < 7);
      r_mtr = $urandom_range(0, 1) == 1;
      r_wn  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r_rdd = $urandom;
      r_mux = $urandom;
      r_rn1 = ($urandom_range(0, 2) == 0) ? r_wn : 5'($urandom_range(0, 31));
      r_rn2 = ($urandom_range(0, 2) == 0) ? r_wn : 5'($urandom_range(0, 31));
      apply(r_we, r_mtr, r_wn, r_rdd, r_mux, r_rn1, r_rn2);
      @(negedge clk);
      compare_all("rand");
      if ($urandom_range(0, 299) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rand_rst");
        #1;
        rst_n = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
